// File: rtl/example_bist_ctrl.sv
// Self-test sequencer for the 3-input `example` block: walks {a,b,c}=0..7, compares y to GOLDEN.
// Latency: 8*(SETTLE+1) cycles from start sample to done; results registered with done.
// Backpressure: none; start is ignored while busy, abort cancels a run and holds the partial results.
module example_bist_ctrl #(
    parameter logic [7:0]  GOLDEN = 8'h31,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERRW   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    output logic            dut_a,
    output logic            dut_b,
    output logic            dut_c,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic [2:0]      fail_idx
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0]      CNT_INIT = 4'(SETTLE - 1);
    localparam logic [ERRW-1:0] ERR_MAX  = '1;

    logic [1:0]      state;
    logic [2:0]      vec;
    logic [3:0]      cnt;
    logic            mismatch;
    logic [ERRW-1:0] err_next;

    // The vector register drives the example inputs directly, so they are registered and hold on abort.
    assign {dut_a, dut_b, dut_c} = vec;
    assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);

    assign mismatch = (dut_y != GOLDEN[vec]);
    assign err_next = (mismatch && (err_count != ERR_MAX)) ? err_count + ERRW'(1) : err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            vec       <= 3'd0;
            cnt       <= 4'd0;
            err_count <= '0;
            fail_idx  <= 3'd0;
            pass      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_SETTLE;
                        vec       <= 3'd0;
                        cnt       <= CNT_INIT;
                        err_count <= '0;
                        fail_idx  <= 3'd0;
                        pass      <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        err_count <= err_next;
                        // err_count only leaves zero on a mismatch, so zero marks "no mismatch seen yet".
                        if (mismatch && (err_count == '0)) begin
                            fail_idx <= vec;
                        end
                        if (vec == 3'd7) begin
                            state <= ST_DONE;
                            pass  <= (err_next == '0);
                        end else begin
                            vec   <= vec + 3'd1;
                            cnt   <= CNT_INIT;
                            state <= ST_SETTLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
